simon_arbiter: RTL and testbench
================================

// Module: simon_arbiter
// PURPOSE
//   Shares one Simon 64/128 encryption core (start/eoc sequenced) between N_REQ requesters.
//   Round-robin arbitration; each requester hands over a block and key via valid/ready,
//   and gets the ciphertext back via valid/ready.
//   Sits between the requester ports and the core; sequences the core's start and waits for its eoc.
// PARAMETERS
//   N_REQ    2    number of requesters (>=1)
//   BLK_W    64   block width
//   KEY_W    128  key width
//   TIMEOUT  48   max WAIT cycles before abort (simon_pkg::N_ROUNDS + 4); used only with macro
// PORTS
//   clk          in   1              clock, rising edge
//   rst          in   1              asynchronous reset, active-high
//   req_valid    in   N_REQ          per-requester request
//   req_ready    out  N_REQ          one-hot accept, combinational, IDLE only
//   req_block    in   N_REQ*BLK_W    plaintext, requester i at [i*BLK_W +: BLK_W]
//   req_key      in   N_REQ*KEY_W    key, requester i at [i*KEY_W +: KEY_W]
//   rsp_valid    out  N_REQ          one-hot response valid (registered)
//   rsp_ready    in   N_REQ          per-requester response accept
//   rsp_block    out  BLK_W          ciphertext for granted requester
//   rsp_err      out  1              response is an abort (timeout), qualifies rsp_valid
//   core_start   out  1              one-cycle start pulse to core
//   core_block   out  BLK_W          registered plaintext to core
//   core_key     out  KEY_W          registered key to core
//   core_eoc     in   1              core end-of-computation
//   core_result  in   BLK_W          core ciphertext, valid with core_eoc
//   busy         out  1              state != IDLE
//   grant_id     out  $clog2(N_REQ)  current/last granted index (width 1 when N_REQ=1)
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; last_grant=N_REQ-1 (requester 0 has first priority).
//   FSM IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
//   IDLE: g = first i with req_valid[i], searching last_grant+1 .. last_grant with wrap.
//     req_ready[g]=1 in the same cycle. On the edge: latch req_block/req_key[g] into
//     core_block/core_key, grant_id=g, go to LAUNCH. No req_valid: stay in IDLE.
//   LAUNCH: core_start=1 for exactly this cycle; go to WAIT. core_eoc is ignored here.
//   WAIT: core_eoc=1 -> rsp_block<=core_result, rsp_err<=0, rsp_valid[g]<=1, go to RESP.
//   RESP: rsp_valid[g] and rsp_block are held stable until rsp_ready[g].
//     On handshake: rsp_valid<=0, last_grant<=g, go to IDLE.
//     Earliest new accept is the cycle after the handshake.
//   core_block/core_key hold from accept until the next accept; requesters may change inputs.
//   req_ready=0 in every state except IDLE. rsp_ready of non-granted requesters is ignored.
//   core_eoc in IDLE, LAUNCH or RESP is ignored (no state change).
//   A requester dropping req_valid before accept is not an error; it is simply not granted.
//   Latency: accept at T, core_start at T+1, rsp_valid 1 cycle after core_eoc.
//   N_REQ=1: grant always 0.
//   rst mid-operation: immediate return to reset values; any transaction in flight is lost;
//     the core is not re-started.
// CONFIGURATION
//   SIMON_ARB_TIMEOUT_EN defined:
//     - 8-bit counter cleared on entering WAIT, increments each WAIT cycle.
//     - Reaching TIMEOUT without core_eoc -> rsp_block<=0, rsp_err<=1, rsp_valid[g]<=1, go to RESP.
//     - core_eoc in the same cycle as the timeout: eoc wins (normal response, rsp_err=0).
//     - rsp_err clears on the response handshake.
//   Not defined: no counter; WAIT lasts until core_eoc; rsp_err is tied 0.
// TESTING
//   1. Reset; req_valid=01, key 1b1a1918_13121110_0b0a0908_03020100, pt 656b696c_20646e75
//      -> req_ready[0] 1 cycle, one core_start next cycle, rsp_valid=01,
//      rsp_block=44c8fc20_b9dfa07a, rsp_err=0.
//   2. req_valid=11 held for 4 transactions (rsp_ready=11) -> grant_id 0,1,0,1; core_start per txn.
//   3. rsp_ready low 10 cycles in RESP -> rsp_valid/rsp_block stable, req_ready=0, no core_start.
//   4. rst pulse during WAIT -> outputs 0 at once; a stale core_eoc afterwards is ignored;
//      the next request (req_valid=11) grants 0.
//   5. SIMON_ARB_TIMEOUT_EN, core never asserts eoc -> after 48 WAIT cycles rsp_valid=01,
//      rsp_err=1, rsp_block=0; same stimulus without macro -> busy=1 after 200 cycles, rsp_err=0.
//   6. SIMON_ARB_TIMEOUT_EN, core_eoc exactly on cycle 48 of WAIT -> rsp_err=0, rsp_block=core_result.

Source files
------------

// File: rtl/simon_arbiter_if.sv
// simon_arbiter_if: requester request/response ports plus the Simon core start/eoc port.
// slave = arbiter view, master = requesters/core/bench view.
interface simon_arbiter_if #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned BLK_W = 64,
   parameter int unsigned KEY_W = 128
);
   localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*BLK_W-1:0] req_block;
   logic [N_REQ*KEY_W-1:0] req_key;
   logic [N_REQ-1:0]       rsp_valid;
   logic [N_REQ-1:0]       rsp_ready;
   logic [BLK_W-1:0]       rsp_block;
   logic                   rsp_err;
   logic                   core_start;
   logic [BLK_W-1:0]       core_block;
   logic [KEY_W-1:0]       core_key;
   logic                   core_eoc;
   logic [BLK_W-1:0]       core_result;
   logic                   busy;
   logic [GW-1:0]          grant_id;

   modport slave (
      input  req_valid, req_block, req_key, rsp_ready, core_eoc, core_result,
      output req_ready, rsp_valid, rsp_block, rsp_err, core_start, core_block, core_key,
             busy, grant_id
   );

   modport master (
      output req_valid, req_block, req_key, rsp_ready, core_eoc, core_result,
      input  req_ready, rsp_valid, rsp_block, rsp_err, core_start, core_block, core_key,
             busy, grant_id
   );
endinterface

// File: rtl/simon_arbiter.sv
// simon_arbiter: round-robin sharing of one Simon 64/128 core between N_REQ requesters.
// Define SIMON_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles with rsp_err=1.
module simon_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned BLK_W = 64,
   parameter int unsigned KEY_W = 128
`ifdef SIMON_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 48
`endif
) (
   input logic            clk,
   input logic            rst,
   simon_arbiter_if.slave bus
);
   localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   state_t           state, state_nxt;
   logic [GW-1:0]    last_grant, last_grant_nxt;
   logic [GW-1:0]    grant, grant_nxt;
   logic [GW-1:0]    pick, idx;
   logic             found, accept, tmo_hit;
   logic             core_start_q, core_start_nxt;
   logic             rsp_err_q, rsp_err_nxt;
   logic             busy_q;
   logic [N_REQ-1:0] req_ready_c;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_nxt;
   logic [BLK_W-1:0] rsp_block_q, rsp_block_nxt;
   logic [BLK_W-1:0] core_block_q;
   logic [KEY_W-1:0] core_key_q;

   // Round-robin search starting just after the last served requester
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = GW'((32'(last_grant) + k) % N_REQ);
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

`ifdef SIMON_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Holds (WAIT cycle number - 1); cleared on the LAUNCH->WAIT transition
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 tmo_cnt <= '0;
      else if (state == LAUNCH) tmo_cnt <= '0;
      else if (state == WAIT)   tmo_cnt <= tmo_cnt + 8'd1;
   end

   assign tmo_hit = (state == WAIT) && (tmo_cnt == 8'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      grant_nxt      = grant;
      rsp_valid_nxt  = rsp_valid_q;
      rsp_block_nxt  = rsp_block_q;
      rsp_err_nxt    = rsp_err_q;
      core_start_nxt = 1'b0;
      accept         = 1'b0;
      req_ready_c    = '0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready_c[pick] = 1'b1;
               accept            = 1'b1;
               grant_nxt         = pick;
               core_start_nxt    = 1'b1;
               state_nxt         = LAUNCH;
            end
         end
         LAUNCH: state_nxt = WAIT;
         WAIT: begin
            // eoc takes priority over a coincident timeout
            if (bus.core_eoc) begin
               rsp_block_nxt        = bus.core_result;
               rsp_err_nxt          = 1'b0;
               rsp_valid_nxt        = '0;
               rsp_valid_nxt[grant] = 1'b1;
               state_nxt            = RESP;
            end else if (tmo_hit) begin
               rsp_block_nxt        = '0;
               rsp_err_nxt          = 1'b1;
               rsp_valid_nxt        = '0;
               rsp_valid_nxt[grant] = 1'b1;
               state_nxt            = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready[grant]) begin
               rsp_valid_nxt  = '0;
               rsp_err_nxt    = 1'b0;
               last_grant_nxt = grant;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_grant   <= GW'(N_REQ - 1);
         grant        <= '0;
         rsp_valid_q  <= '0;
         rsp_block_q  <= '0;
         rsp_err_q    <= 1'b0;
         core_start_q <= 1'b0;
         core_block_q <= '0;
         core_key_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_grant   <= last_grant_nxt;
         grant        <= grant_nxt;
         rsp_valid_q  <= rsp_valid_nxt;
         rsp_block_q  <= rsp_block_nxt;
         rsp_err_q    <= rsp_err_nxt;
         core_start_q <= core_start_nxt;
         busy_q       <= (state_nxt != IDLE);
         if (accept) begin
            core_block_q <= bus.req_block[32'(pick) * BLK_W +: BLK_W];
            core_key_q   <= bus.req_key[32'(pick) * KEY_W +: KEY_W];
         end
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_block  = rsp_block_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.core_start = core_start_q;
   assign bus.core_block = core_block_q;
   assign bus.core_key   = core_key_q;
   assign bus.busy       = busy_q;
   assign bus.grant_id   = grant;
endmodule

// File: tb/tb_simon_arbiter.sv
// tb_simon_arbiter: randomized bench with a Simon 64/128 core model and a round-robin reference.
// Timeout expectations follow SIMON_ARB_TIMEOUT_EN when it is defined for the build.
module tb_simon_arbiter;
   localparam int unsigned N  = 2;
   localparam int unsigned BW = 64;
   localparam int unsigned KW = 128;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   simon_arbiter_if #(.N_REQ(N), .BLK_W(BW), .KEY_W(KW)) bus ();
   simon_arbiter #(.N_REQ(N), .BLK_W(BW), .KEY_W(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int lg;
   int core_lat;
   bit core_pend;
   int core_k;
   logic [63:0]  core_pt;
   logic [127:0] core_ky;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Simon 64/128 encryption, straight from the cipher definition
   function automatic logic [63:0] simon(input logic [63:0] pt, input logic [127:0] key);
      logic [31:0] rk [44];
      logic [63:0] z;
      logic [31:0] x, y, t;
      z = 64'hfc2ce51207a635db;
      for (int i = 0; i < 4; i++) rk[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         rk[i] = 32'hfffffffc ^ {31'd0, z[0]} ^ rk[i-4] ^ ror(rk[i-1], 3) ^ rk[i-3]
                 ^ ror(rk[i-1], 4) ^ ror(rk[i-3], 1);
         z = z >> 1;
      end
      x = pt[63:32];
      y = pt[31:0];
      for (int i = 0; i < 44; i++) begin
         t = x;
         x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ rk[i];
         y = t;
      end
      return {x, y};
   endfunction

   function automatic int rr(input int last, input logic [N-1:0] v);
      int i;
      for (int k = 1; k <= N; k++) begin
         i = (last + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Core model: eoc on the core_lat-th cycle after the start pulse (never if core_lat<=0)
   initial begin
      bus.core_eoc    = 1'b0;
      bus.core_result = '0;
      core_pend       = 1'b0;
      core_k          = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.core_eoc = 1'b0;
         if (bus.core_start) begin
            core_pend = 1'b1;
            core_k    = 0;
            core_pt   = bus.core_block;
            core_ky   = bus.core_key;
         end else if (core_pend) begin
            core_k++;
            if (core_lat > 0 && core_k == core_lat) begin
               bus.core_eoc    = 1'b1;
               bus.core_result = simon(core_pt, core_ky);
               core_pend       = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) begin
         bus.req_block[i*BW +: BW] = {$urandom, $urandom};
         bus.req_key[i*KW +: KW]   = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_core_start", bus.core_start, 0);
      check("rst_grant", bus.grant_id, 0);
      check("rst_core_block", bus.core_block, 0);
      check("rst_rsp_block", bus.rsp_block, 0);
      step();
      rst = 1'b0;
      lg  = N - 1;
   endtask

   // One full transaction starting in an IDLE cycle; returns observed grant_id
   task automatic txn(input logic [N-1:0] v, input int lat, input int hold, output int g);
      int gexp, n;
      bit restart;
      logic [N-1:0]   oh;
      logic [63:0]    b, exp_blk;
      logic [127:0]   k;
      gexp     = rr(lg, v);
      oh       = '0;
      oh[gexp] = 1'b1;
      core_lat = lat;
      bus.req_valid = v;
      #1;
      check("req_ready", bus.req_ready, oh);
      check("busy_idle", bus.busy, 0);
      b       = bus.req_block[gexp*BW +: BW];
      k       = bus.req_key[gexp*KW +: KW];
      exp_blk = simon(b, k);
      step();
      g = int'(bus.grant_id);
      check("grant_id", bus.grant_id, gexp);
      check("core_start", bus.core_start, 1);
      check("core_block", bus.core_block, b);
      check("core_key", bus.core_key, k);
      check("busy_launch", bus.busy, 1);
      check("req_ready_launch", bus.req_ready, 0);
      bus.req_valid = N'($urandom);
      rand_data();
      n       = 0;
      restart = 1'b0;
      do begin
         step();
         n++;
         if (bus.core_start) restart = 1'b1;
      end while (bus.rsp_valid == 0 && n < lat + 8);
      check("no_restart", restart, 0);
      check("rsp_latency", n, lat + 1);
      if (bus.rsp_valid == 0) begin
         do_reset();
         g = -1;
         return;
      end
      check("rsp_valid", bus.rsp_valid, oh);
      check("rsp_block", bus.rsp_block, exp_blk);
      check("rsp_err", bus.rsp_err, 0);
      check("core_block_hold", bus.core_block, b);
      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = N'($urandom) & ~oh;
         bus.req_valid = N'($urandom);
         step();
         check("hold_rsp_valid", bus.rsp_valid, oh);
         check("hold_rsp_block", bus.rsp_block, exp_blk);
         check("hold_req_ready", bus.req_ready, 0);
         check("hold_core_start", bus.core_start, 0);
      end
      bus.rsp_ready = oh | N'($urandom);
      step();
      bus.rsp_ready = '0;
      bus.req_valid = '0;
      check("rsp_valid_clr", bus.rsp_valid, 0);
      check("busy_clr", bus.busy, 0);
      lg = gexp;
   endtask

   initial begin
      int g, n;
      bit seen;
      logic [N-1:0] v;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_block = '0;
      bus.req_key   = '0;
      core_lat      = 1;
      lg            = N - 1;
      #12;
      check("reset_busy", bus.busy, 0);
      check("reset_rsp_valid", bus.rsp_valid, 0);
      check("reset_rsp_err", bus.rsp_err, 0);
      check("reset_core_start", bus.core_start, 0);
      check("reset_grant", bus.grant_id, 0);
      check("reset_req_ready", bus.req_ready, 0);
      rst = 1'b0;
      step();

      // Known-answer vector through requester 0
      bus.req_block[0 +: BW] = 64'h656b696c20646e75;
      bus.req_key[0 +: KW]   = 128'h1b1a1918131211100b0a090803020100;
      txn(2'b01, 3, 0, g);
      check("kat_block", bus.rsp_block, 64'h44c8fc20b9dfa07a);

      // Both requesting: alternate 0,1,0,1 from reset
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rand_data();
         txn(2'b11, 2 + i, 0, g);
         check("rr_order", g, i % 2);
      end

      // Response back-pressure for 10 cycles
      rand_data();
      txn(2'b10, 4, 10, g);

      // Reset during WAIT, then a stale eoc from the core
      rand_data();
      core_lat      = 6;
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = '0;
      step();
      step();
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.busy || bus.rsp_valid != 0 || bus.core_start) seen = 1'b1;
      end
      check("stale_eoc_ignored", seen, 0);
      rand_data();
      txn(2'b11, 3, 0, g);
      check("post_reset_grant", g, 0);

      // Core that never finishes
      rand_data();
      core_lat      = 0;
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = '0;
`ifdef SIMON_ARB_TIMEOUT_EN
      n = 0;
      do begin
         step();
         n++;
      end while (bus.rsp_valid == 0 && n < 80);
      check("tmo_latency", n, 49);
      check("tmo_rsp_valid", bus.rsp_valid, 2'b01);
      check("tmo_rsp_err", bus.rsp_err, 1);
      check("tmo_rsp_block", bus.rsp_block, 0);
      bus.rsp_ready = 2'b01;
      step();
      bus.rsp_ready = '0;
      check("tmo_err_clr", bus.rsp_err, 0);
      check("tmo_valid_clr", bus.rsp_valid, 0);
      lg = 0;
`else
      n = 0;
      repeat (200) step();
      check("hang_busy", bus.busy, 1);
      check("hang_rsp_err", bus.rsp_err, 0);
      check("hang_rsp_valid", bus.rsp_valid, 0);
      do_reset();
`endif

      // eoc on WAIT cycle 48: a normal response even with the timeout enabled
      rand_data();
      txn(2'b01, 48, 0, g);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         rand_data();
         v = N'($urandom);
         if (v == 0) v = N'(1) << $urandom_range(0, N - 1);
         txn(v, $urandom_range(1, 10), $urandom_range(0, 3), g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
endmodule
